dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port data memory (64 x 32-bit, word-addressed, registered read, separate write/read strobes).
- Master 0 is the CPU MEM stage. Master 1 is the debug/program-loader port.
- The arbiter owns the memory's write strobe, read strobe, address and data inputs. It returns read data to the winning master with a valid pulse.
- Fixed priority to master 0, with starvation protection for master 1.

Parameters:
- AW, 32, address width of master and memory address ports
- DW, 32, data width
- DEPTH, 64, number of memory words; addresses >= DEPTH are out of range
- STARVE_LIMIT, 4, consecutive m0 grants allowed while m1 is waiting; the next arbitration then goes to m1
- CW, 3, starvation counter width; must satisfy 2^CW > STARVE_LIMIT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held with m0_we, m0_addr and m0_wdata stable until m0_gnt
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  AW  word address
- m0_wdata  in  DW  write data
- m0_gnt  out  1  one-cycle pulse: request accepted and latched
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  DW  read data
- m0_err  out  1  one-cycle pulse with gnt: address out of range
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0, for master 1
- mem_we  out  1  to memory write enable
- mem_re  out  1  to memory read enable
- mem_addr  out  AW  to memory address
- mem_wdata  out  DW  to memory write data
- mem_rdata  in  DW  from memory registered read output
- busy  out  1  1 when the FSM is not in IDLE

Behaviour:
- Reset values: state=IDLE; all gnt, rvalid, err, mem_we, mem_re and busy = 0; rdata, mem_addr, mem_wdata = 0; starvation count = 0.
- Reset mid-transaction abandons the transaction. A write that has not yet reached ACCESS is never issued. Masters re-request after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select a winner, latch its we/addr/wdata and its id, and go to ACCESS.
  - If no req is high, stay in IDLE.
- Winner selection:
  - Only m0 requesting: m0.
  - Only m1 requesting: m1.
  - Both requesting: m1 if count == STARVE_LIMIT, else m0.
- Starvation count:
  - Increments when m0 is granted while m1_req is high.
  - Clears when m1 is granted, or when m1_req is low in IDLE.
  - Saturates at STARVE_LIMIT.
- ACCESS (exactly 1 cycle):
  - Assert the winner's gnt.
  - Drive mem_addr and mem_wdata from the latched values.
  - In-range write: mem_we=1.
  - In-range read: mem_re=1.
  - mem_we and mem_re are never high together. Both are 0 in all other states, so the memory output holds.
  - Out of range: both strobes stay 0 and the winner's err pulses together with gnt.
  - Next state: RESP for any read (including out of range), IDLE for a write.
- RESP (1 cycle):
  - Winner's rvalid=1.
  - rdata = mem_rdata, or 0 if the read was out of range.
  - The other master's rdata holds its last value.
  - Next state is IDLE.
- Latency:
  - Request seen in cycle N gives gnt in N+1.
  - A write commits at the edge ending N+1.
  - rvalid occurs in N+2.
  - Minimum issue interval is 2 cycles for writes and 3 cycles for reads.
- A master that keeps req high after its gnt is treated as a new request at the next IDLE.
- The non-granted master's req is ignored outside IDLE. It must hold its request; nothing is queued.

Test Plan:
- Reset: rst=1 mid-ACCESS of an m0 write to addr 5 → all outputs 0 immediately, state IDLE; after release, a read of addr 5 returns the prior contents.
- Single master: m0 writes 0xDEADBEEF to addr 3 (req at cycle 0) → gnt in cycle 1, mem_we=1 in cycle 1. m0 then reads addr 3 → gnt, then rvalid in the next cycle with rdata=0xDEADBEEF; mem_re high for exactly 1 cycle.
- Contention: m0 and m1 both request reads in the same cycle, count=0 → m0 granted first; m1 granted at the next IDLE after m0 drops req.
- Starvation: m0 and m1 both hold req continuously (m1 is a write of 0x55 to addr 7) → m0 is granted 4 times, then m1 is granted. mem_we=1 with mem_addr=7 in m1's ACCESS cycle. Count returns to 0 and m0 is granted next.
- Out of range: m1 writes addr 64 → m1_gnt and m1_err pulse together, mem_we stays 0, memory is unchanged. m1 reads addr 100 → err with gnt, then rvalid with rdata=0.
- Back-to-back: m0 issues a write to addr 1, then immediately a read of addr 1 → read returns the new data. The write's IDLE-to-IDLE interval is 2 cycles and the read's gnt-to-rvalid is 1 cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory.
// Fixed priority to m0, with a starvation counter that forces an m1 grant.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int DEPTH        = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // state  | meaning
    // IDLE   | arbitrate, latch winner's request
    // ACCESS | gnt (and err) pulse, memory strobe issued
    // RESP   | read data returned to winner with rvalid
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic          sel;
    logic          lat_we;
    logic          lat_oor;
    logic [CW-1:0] starve_cnt;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;

    logic          pick_m1;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_oor;
    logic [DW-1:0] resp_data;

    always_comb begin
        pick_m1   = m1_req && (!m0_req || (starve_cnt == CW'(STARVE_LIMIT)));
        win_we    = pick_m1 ? m1_we    : m0_we;
        win_addr  = pick_m1 ? m1_addr  : m0_addr;
        win_wdata = pick_m1 ? m1_wdata : m0_wdata;
        win_oor   = (win_addr >= AW'(DEPTH));
        resp_data = lat_oor ? '0 : mem_rdata;
    end

    // Memory output is registered, so read data is passed straight through during RESP.
    assign m0_rdata = (state == RESP && !sel) ? resp_data : m0_rdata_q;
    assign m1_rdata = (state == RESP &&  sel) ? resp_data : m1_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 1'b0;
            lat_we     <= 1'b0;
            lat_oor    <= 1'b0;
            starve_cnt <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        sel       <= pick_m1;
                        lat_we    <= win_we;
                        lat_oor   <= win_oor;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        m0_gnt    <= !pick_m1;
                        m1_gnt    <= pick_m1;
                        m0_err    <= !pick_m1 && win_oor;
                        m1_err    <= pick_m1 && win_oor;
                        mem_we    <= win_we && !win_oor;
                        mem_re    <= !win_we && !win_oor;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                        if (pick_m1 || !m1_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= RESP;
                        m0_rvalid <= !sel;
                        m1_rvalid <= sel;
                    end
                end
                RESP: begin
                    if (sel) begin
                        m1_rdata_q <= resp_data;
                    end else begin
                        m0_rdata_q <= resp_data;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
